// File: rtl/eq_pkg.sv
// Shared constants and types for the equalizer gain sequencer.
package eq_pkg;

  localparam int NBANDS = 8;
  localparam int GW     = 8;
  localparam int BW     = $clog2(NBANDS);

  typedef logic signed [GW-1:0] gain_t;

  typedef enum logic {IDLE, SCAN} eq_seq_state_e;

endpackage

// File: rtl/gain_step_unit.sv
// Saturating one-step ramp: moves cur toward tgt by at most STEP, never past
// tgt and never wrapping. Pure combinational.
module gain_step_unit
  import eq_pkg::*;
#(
  parameter int STEP = 1
) (
  input  gain_t cur,
  input  gain_t tgt,
  output gain_t nxt
);

  localparam logic signed [GW:0] STEP_W = (GW+1)'(STEP);

  logic signed [GW:0] cur_w;
  logic signed [GW:0] tgt_w;
  logic signed [GW:0] diff;
  logic signed [GW:0] sum;

  // One extra bit keeps the difference exact across the full signed range.
  always_comb begin
    cur_w = {cur[GW-1], cur};
    tgt_w = {tgt[GW-1], tgt};
    diff  = tgt_w - cur_w;
    if (diff > STEP_W)
      sum = cur_w + STEP_W;
    else if (diff < -STEP_W)
      sum = cur_w - STEP_W;
    else
      sum = tgt_w;
    nxt = sum[GW-1:0];
  end

endmodule

// File: rtl/eq_gain_sequencer.sv
// Per-band gain ramp controller for the 8-band equalizer: one band stepped per
// cycle on each sample tick. Define EQ_GAIN_READBACK_EN to add target/current readback.
module eq_gain_sequencer
  import eq_pkg::*;
#(
  parameter int    STEP      = 1,
  parameter gain_t GAIN_INIT = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_tick,
  input  logic          mute,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [BW-1:0] cfg_band,
  input  gain_t         cfg_gain,
  output gain_t         g [NBANDS],
  output logic          busy,
  output logic          settled,
  output logic          tick_overrun
`ifdef EQ_GAIN_READBACK_EN
  ,
  input  logic [BW-1:0] rd_band,
  output gain_t         rd_target,
  output gain_t         rd_current
`endif
);

  eq_seq_state_e state, state_d;
  logic [BW-1:0] idx;
  gain_t         tgt [NBANDS];
  gain_t         cur [NBANDS];
  gain_t         eff [NBANDS];
  gain_t         step_out;
  logic          band_ok;

  assign band_ok = ({1'b0, cfg_band} < (BW+1)'(NBANDS));

  always_comb begin
    for (int i = 0; i < NBANDS; i++) begin
      eff[i] = mute ? gain_t'(0) : tgt[i];
    end
  end

  gain_step_unit #(.STEP(STEP)) u_step (
    .cur (cur[idx]),
    .tgt (eff[idx]),
    .nxt (step_out)
  );

  always_comb begin
    state_d   = state;
    busy      = 1'b0;
    cfg_ready = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (sample_tick) state_d = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (idx == BW'(NBANDS-1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      tick_overrun <= 1'b0;
      for (int i = 0; i < NBANDS; i++) begin
        tgt[i] <= GAIN_INIT;
        cur[i] <= GAIN_INIT;
      end
    end else begin
      state <= state_d;
      if (state == IDLE) begin
        if (cfg_valid && band_ok) tgt[cfg_band] <= cfg_gain;
        if (sample_tick) idx <= '0;
      end else begin
        cur[idx] <= step_out;
        idx      <= idx + 1'b1;
        if (sample_tick) tick_overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    settled = (state == IDLE);
    for (int i = 0; i < NBANDS; i++) begin
      if (cur[i] != eff[i]) settled = 1'b0;
    end
  end

  assign g = cur;

`ifdef EQ_GAIN_READBACK_EN
  always_comb begin
    rd_target  = '0;
    rd_current = '0;
    if ({1'b0, rd_band} < (BW+1)'(NBANDS)) begin
      rd_target  = tgt[rd_band];
      rd_current = cur[rd_band];
    end
  end
`endif

endmodule

// File: tb/tb_eq_gain_sequencer.sv
// Directed bench: four sequencer instances (STEP 1, 2, 4, 64) share one set of
// inputs; each scenario checks the instance whose step size it exercises.
module tb_eq_gain_sequencer;
  import eq_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_tick = 1'b0;
  logic          mute = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [BW-1:0] cfg_band = '0;
  gain_t         cfg_gain = '0;

  gain_t g1 [NBANDS];
  gain_t g2 [NBANDS];
  gain_t g4 [NBANDS];
  gain_t g64 [NBANDS];
  logic  ready1, ready2, ready4, ready64;
  logic  busy1, busy2, busy4, busy64;
  logic  settled1, settled2, settled4, settled64;
  logic  ovr1, ovr2, ovr4, ovr64;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  eq_gain_sequencer #(.STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .mute(mute),
    .cfg_valid(cfg_valid), .cfg_ready(ready1), .cfg_band(cfg_band), .cfg_gain(cfg_gain),
    .g(g1), .busy(busy1), .settled(settled1), .tick_overrun(ovr1));

  eq_gain_sequencer #(.STEP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .mute(mute),
    .cfg_valid(cfg_valid), .cfg_ready(ready2), .cfg_band(cfg_band), .cfg_gain(cfg_gain),
    .g(g2), .busy(busy2), .settled(settled2), .tick_overrun(ovr2));

  eq_gain_sequencer #(.STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .mute(mute),
    .cfg_valid(cfg_valid), .cfg_ready(ready4), .cfg_band(cfg_band), .cfg_gain(cfg_gain),
    .g(g4), .busy(busy4), .settled(settled4), .tick_overrun(ovr4));

  eq_gain_sequencer #(.STEP(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .mute(mute),
    .cfg_valid(cfg_valid), .cfg_ready(ready64), .cfg_band(cfg_band), .cfg_gain(cfg_gain),
    .g(g64), .busy(busy64), .settled(settled64), .tick_overrun(ovr64));

  task automatic do_reset();
    sample_tick = 1'b0;
    cfg_valid   = 1'b0;
    mute        = 1'b0;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_cfg(input int band, input int gain);
    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_band  = BW'(band);
    cfg_gain  = gain_t'(gain);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  // Leaves the caller just inside cycle T+1 of a tick issued in cycle T.
  task automatic pulse_tick();
    @(posedge clk); #1;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
  endtask

  task automatic tick_and_finish();
    pulse_tick();
    repeat (12) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < NBANDS; i++) begin
      checks++;
      if (g2[i] !== gain_t'(0)) begin
        failures++;
        $display("[TB] FAIL reset_g band=%0d got=%0d want=0", i, g2[i]);
      end
    end
    checks++;
    if ({settled2, ready2, ovr2, busy2} !== 4'b1100) begin
      failures++;
      $display("[TB] FAIL reset_flags got settled/ready/ovr/busy=%b want=1100",
               {settled2, ready2, ovr2, busy2});
    end
    write_cfg(0, 5);
    pulse_tick();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (g1[0] !== gain_t'(1)) begin
      failures++;
      $display("[TB] FAIL midscan_pre got=%0d want=1", g1[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (g1[0] !== gain_t'(0) || busy1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midscan_reset got g0=%0d busy=%b want g0=0 busy=0", g1[0], busy1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_step2();
    int exp_seq [3] = '{2, 4, 5};
    do_reset();
    write_cfg(3, 5);
    for (int n = 0; n < 3; n++) begin
      pulse_tick();
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++;
      if (g2[3] !== gain_t'(exp_seq[n]) || g2[2] !== gain_t'(0) || g2[4] !== gain_t'(0)) begin
        failures++;
        $display("[TB] FAIL step2_tick%0d got g3=%0d g2=%0d g4=%0d want g3=%0d others=0",
                 n, g2[3], g2[2], g2[4], exp_seq[n]);
      end
      repeat (15) @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (settled2 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL step2_settled got=%b want=1", settled2);
    end
  endtask

  task automatic test_step64_extremes();
    int up_seq [2] = '{64, 127};
    int dn_seq [4] = '{63, -1, -65, -128};
    do_reset();
    write_cfg(0, 127);
    for (int n = 0; n < 2; n++) begin
      tick_and_finish();
      checks++;
      if (g64[0] !== gain_t'(up_seq[n])) begin
        failures++;
        $display("[TB] FAIL step64_up%0d got=%0d want=%0d", n, g64[0], up_seq[n]);
      end
    end
    write_cfg(0, -128);
    for (int n = 0; n < 4; n++) begin
      tick_and_finish();
      checks++;
      if (g64[0] !== gain_t'(dn_seq[n])) begin
        failures++;
        $display("[TB] FAIL step64_down%0d got=%0d want=%0d", n, g64[0], dn_seq[n]);
      end
    end
  endtask

  task automatic test_mute();
    int mute_seq [3]   = '{6, 2, 0};
    int unmute_seq [3] = '{4, 8, 10};
    int bad;
    do_reset();
    for (int b = 0; b < NBANDS; b++) write_cfg(b, 10);
    for (int n = 0; n < 3; n++) tick_and_finish();
    checks++;
    if (settled4 !== 1'b1 || g4[5] !== gain_t'(10)) begin
      failures++;
      $display("[TB] FAIL mute_presettle got settled=%b g5=%0d want settled=1 g5=10", settled4, g4[5]);
    end
    mute = 1'b1;
    #1;
    checks++;
    if (settled4 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mute_unsettled got=%b want=0", settled4);
    end
    for (int n = 0; n < 3; n++) begin
      tick_and_finish();
      bad = 0;
      for (int b = 0; b < NBANDS; b++) if (g4[b] !== gain_t'(mute_seq[n])) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("[TB] FAIL mute_tick%0d bad_bands=%0d g0=%0d want all=%0d", n, bad, g4[0], mute_seq[n]);
      end
    end
    mute = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick_and_finish();
      bad = 0;
      for (int b = 0; b < NBANDS; b++) if (g4[b] !== gain_t'(unmute_seq[n])) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("[TB] FAIL unmute_tick%0d bad_bands=%0d g7=%0d want all=%0d", n, bad, g4[7], unmute_seq[n]);
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    @(posedge clk); #1;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    cfg_valid   = 1'b1;
    cfg_band    = BW'(7);
    cfg_gain    = gain_t'(-3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    @(negedge clk);
    checks++;
    if (ovr1 !== 1'b1 || ready1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overrun_flag got ovr=%b ready=%b want ovr=1 ready=0", ovr1, ready1);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready1 !== 1'b0 || busy1 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL overrun_lastscan got ready=%b busy=%b want ready=0 busy=1", ready1, busy1);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready1 !== 1'b1 || busy1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overrun_idle got ready=%b busy=%b want ready=1 busy=0", ready1, busy1);
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    checks++;
    if (g1[7] !== gain_t'(0)) begin
      failures++;
      $display("[TB] FAIL overrun_g7_before got=%0d want=0", g1[7]);
    end
    tick_and_finish();
    checks++;
    if (g1[7] !== gain_t'(-1) || ovr1 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL overrun_g7_after got g7=%0d ovr=%b want g7=-1 ovr=1", g1[7], ovr1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(posedge clk); #1;
    cfg_valid   = 1'b1;
    cfg_band    = BW'(0);
    cfg_gain    = gain_t'(1);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    cfg_valid   = 1'b0;
    sample_tick = 1'b0;
    @(negedge clk);
    checks++;
    if (g1[0] !== gain_t'(0) || busy1 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL same_cycle_t1 got g0=%0d busy=%b want g0=0 busy=1", g1[0], busy1);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (g1[0] !== gain_t'(1)) begin
      failures++;
      $display("[TB] FAIL same_cycle_t2 got=%0d want=1", g1[0]);
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (settled1 !== 1'b1 || ovr1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL same_cycle_end got settled=%b ovr=%b want settled=1 ovr=0", settled1, ovr1);
    end
  endtask

  initial begin
    test_reset();
    test_step2();
    test_step64_extremes();
    test_mute();
    test_overrun();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
